pico_bus_reader: RTL and testbench

- Bus initiator on the PicoRV32 native memory interface; the requester side that drives program-memory and peripheral responders.
- Accepts a burst command (start address, word count) and issues sequential single-word reads on the bus.
- Streams returned words out on a valid/ready interface; the SHA-256 datapath uses it to pull message blocks and constants without the CPU.
- Per-access timeout guards against responders that never assert ready.

---
 rtl/pico_bus_pkg.sv | 26 ++
 rtl/pico_bus_timeout.sv | 33 +++
 rtl/pico_bus_reader.sv | 141 ++++++++++++++
 tb/tb_pico_bus_reader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_bus_pkg.sv
// rtl/pico_bus_pkg.sv - shared types and constants for the PicoRV32 native-bus burst reader
package pico_bus_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;

    localparam logic [3:0] WSTRB_READ = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        OUT,
        FIN
    } state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    // Sequential word address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/pico_bus_timeout.sv
// rtl/pico_bus_timeout.sv - per-access wait counter with clear, enable and expiry flag
module pico_bus_timeout
    import pico_bus_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] LAST   = LAST_I[TO_W-1:0];

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    // Fires in the last allowed cycle, so the access sees exactly TIMEOUT request cycles.
    assign expired = (TIMEOUT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/pico_bus_reader.sv
// rtl/pico_bus_reader.sv - burst read initiator on the PicoRV32 native memory interface
module pico_bus_reader
    import pico_bus_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             mem_valid,
    output logic             mem_instr,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   rem_q;
    logic [DATA_W-1:0]  data_q;
    logic               last_q;
    logic               mem_valid_q;
    logic               out_valid_q;
    logic               done_q;
    logic               err_q;

    logic               hit;
    logic               to_en;
    logic               to_clr;
    logic               to_expired;

    // A ready seen while no request is outstanding is a stale echo and never counts.
    assign hit    = mem_valid_q && mem_ready;
    assign to_en  = (state_q == REQ);
    assign to_clr = !to_en || hit;

    pico_bus_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= word_align(cmd_addr);
                        rem_q  <= cmd_len;
                        err_q  <= 1'b0;
                        if (cmd_len == '0) begin
                            state_q <= FIN;
                        end else begin
                            state_q     <= REQ;
                            mem_valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Data arriving in the expiry cycle still wins over the timeout.
                    if (hit) begin
                        data_q      <= mem_rdata;
                        last_q      <= (rem_q == LEN_W'(1));
                        mem_valid_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (to_expired) begin
                        mem_valid_q <= 1'b0;
                        err_q       <= 1'b1;
                        state_q     <= FIN;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        last_q      <= 1'b0;
                        rem_q       <= rem_q - LEN_W'(1);
                        addr_q      <= next_word(addr_q);
                        if (last_q) begin
                            state_q <= FIN;
                        end else begin
                            state_q     <= REQ;
                            mem_valid_q <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_instr = 1'b0;
    assign mem_addr  = addr_q;
    assign mem_wstrb = WSTRB_READ;
    assign mem_wdata = '0;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pico_bus_reader.sv
// tb/tb_pico_bus_reader.sv - self-checking bench for pico_bus_reader
module tb_pico_bus_reader;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 64;
    localparam int TO_W    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             mem_valid;
    logic             mem_instr;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_wdata;
    logic             mem_ready;
    logic [31:0]      mem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    pico_bus_reader #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          lat;
        logic [31:0] key;
        bit          stall;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_words;
        bit          exp_err;
    } vec_t;

    vec_t        tbl[7];
    int          vecs = 0;
    int          miscompares = 0;
    int          cyc = 0;

    logic [31:0] bus_addr_q[$];
    int          bus_len_q[$];
    logic [31:0] got_data[$];
    bit          got_last[$];
    int          done_cnt, done_cyc, acc_cyc;
    bit          done_err;

    int          resp_lat, rdy_pct, stall_left;
    logic [31:0] resp_key;
    bit          stale_en, stall_mode;
    int          wait_cnt, cur_vcyc;
    bit          prev_valid, prev_hit, hold_pend, hold_last;
    logic [31:0] prev_addr, hold_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: responder, consumer and observation, all evaluated mid-cycle.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rst) begin
            wait_cnt = 0; cur_vcyc = 0; prev_valid = 0; prev_hit = 0; hold_pend = 0;
            mem_ready = 1'b0; mem_rdata = '0; out_ready = 1'b0;
            return;
        end
        if (mem_valid) begin
            if (!prev_valid) begin
                bus_addr_q.push_back(mem_addr);
                cur_vcyc = 0;
                wait_cnt = 0;
            end else begin
                check("mem_addr_stable", mem_addr, prev_addr);
            end
            cur_vcyc++;
            wait_cnt++;
            mem_ready = (wait_cnt > resp_lat);
            mem_rdata = mem_ready ? (mem_addr ^ resp_key) : $urandom;
        end else begin
            if (prev_valid) bus_len_q.push_back(cur_vcyc);
            mem_ready = stale_en && prev_hit;
            mem_rdata = $urandom;
        end
        prev_hit   = mem_valid && mem_ready;
        prev_valid = mem_valid;
        prev_addr  = mem_addr;

        if (stall_mode && out_valid && got_data.size() == 1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (stall_mode) begin
            out_ready = 1'b1;
        end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
        end

        if (out_valid) begin
            check("no_req_during_out", 32'(mem_valid), 32'd0);
            if (hold_pend) begin
                check("out_data_hold", out_data, hold_data);
                check("out_last_hold", 32'(out_last), 32'(hold_last));
            end
            if (out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                hold_pend = 0;
            end else begin
                hold_pend = 1;
                hold_data = out_data;
                hold_last = out_last;
            end
        end else begin
            if (hold_pend) check("out_valid_dropped", 32'd0, 32'd1);
            hold_pend = 0;
        end

        if (done) begin
            done_cnt++;
            done_err = err;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_obs();
        bus_addr_q.delete();
        bus_len_q.delete();
        got_data.delete();
        got_last.delete();
        done_cnt = 0;
        done_err = 0;
        done_cyc = 0;
    endtask

    task automatic configure(input int lat, input logic [31:0] key, input bit stall,
                             input int pct, input bit stale);
        resp_lat   = lat;
        resp_key   = key;
        stall_mode = stall;
        stall_left = stall ? 5 : 0;
        rdy_pct    = pct;
        stale_en   = stale;
    endtask

    task automatic issue_cmd(input logic [31:0] addr, input int len);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            step();
            n++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        acc_cyc   = cyc;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_len   = LEN_W'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("cmd_ready_when_busy", 32'(cmd_ready), 32'd0);
        check("err_cleared_on_accept", 32'(err), 32'd0);
    endtask

    task automatic run_burst(input logic [31:0] addr, input int len, input int lat,
                             input logic [31:0] key, input bit stall, input int pct, input bit stale);
        int n;
        configure(lat, key, stall, pct, stale);
        clear_obs();
        issue_cmd(addr, len);
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            step();
            n++;
        end
        if (done_cnt == 0) check("done_within_bound", 32'd0, 32'd1);
        repeat (3) step();
    endtask

    // Expected burst outcome from the rules: word-aligned sequential addresses,
    // TIMEOUT request cycles per access, and ready on the expiry cycle still delivering.
    task automatic check_model(input logic [31:0] addr, input int len, input int lat,
                               input logic [31:0] key);
        logic [31:0] base, a;
        bit          timed_out;
        int          nwords, nreq, vlen;
        base      = {addr[31:2], 2'b00};
        timed_out = (len > 0) && (lat + 1 > TIMEOUT);
        nwords    = timed_out ? 0 : len;
        nreq      = timed_out ? 1 : len;
        vlen      = (lat + 1 < TIMEOUT) ? lat + 1 : TIMEOUT;
        check("done_once", 32'(done_cnt), 32'd1);
        check("done_err", 32'(done_err), 32'(timed_out));
        check("word_count", 32'(got_data.size()), 32'(nwords));
        check("req_count", 32'(bus_addr_q.size()), 32'(nreq));
        check("req_ended_count", 32'(bus_len_q.size()), 32'(nreq));
        for (int i = 0; i < nreq && i < bus_addr_q.size(); i++) begin
            a = base + 32'(4 * i);
            check("req_addr", bus_addr_q[i], a);
            if (i < bus_len_q.size()) check("req_valid_cycles", 32'(bus_len_q[i]), 32'(vlen));
        end
        for (int i = 0; i < nwords && i < got_data.size(); i++) begin
            a = base + 32'(4 * i);
            check("out_data", got_data[i], a ^ key);
            check("out_last", 32'(got_last[i]), 32'(i == nwords - 1));
        end
        if (len == 0) check("zero_len_done_latency", 32'(done_cyc - acc_cyc), 32'd2);
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_tied", {mem_wdata[31:5], mem_wstrb, mem_instr}, 32'd0);
    endtask

    initial begin
        int          n, d0, len, lat;
        logic [31:0] addr;

        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        mem_ready = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        configure(1, 32'h0, 1'b0, 100, 1'b0);
        clear_obs();

        tbl[0] = '{32'h0010_0000, 4, 1,  32'h0000_0000, 1'b0, 32'h0010_0000, 32'h0010_000C, 4, 1'b0};
        tbl[1] = '{32'h0010_0000, 4, 1,  32'h0000_0000, 1'b1, 32'h0010_0000, 32'h0010_000C, 4, 1'b0};
        tbl[2] = '{32'h0000_0123, 0, 1,  32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0};
        tbl[3] = '{32'hFFFF_FFFE, 2, 1,  32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 2, 1'b0};
        tbl[4] = '{32'h0000_1003, 1, 63, 32'h5A5A_0000, 1'b0, 32'h0000_1000, 32'h0000_1000, 1, 1'b0};
        tbl[5] = '{32'h0000_2000, 3, 64, 32'h0000_0000, 1'b0, 32'h0000_2000, 32'h0000_2000, 0, 1'b1};
        tbl[6] = '{32'hDEAD_BEEF, 5, 0,  32'h0F0F_0F0F, 1'b0, 32'hDEAD_BEEC, 32'hDEAD_BEFC, 5, 1'b0};

        repeat (2) step();
        check_reset_outputs();
        rst = 1'b0;
        step();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_burst(tbl[i].addr, tbl[i].len, tbl[i].lat, tbl[i].key, tbl[i].stall, 100, i[0]);
            check_model(tbl[i].addr, tbl[i].len, tbl[i].lat, tbl[i].key);
            check("tbl_words", 32'(got_data.size()), 32'(tbl[i].exp_words));
            check("tbl_err", 32'(done_err), 32'(tbl[i].exp_err));
            if (bus_addr_q.size() > 0) begin
                check("tbl_first_addr", bus_addr_q[0], tbl[i].exp_first);
                check("tbl_last_addr", bus_addr_q[bus_addr_q.size() - 1], tbl[i].exp_last);
            end
        end

        // Responder that never answers: abort after TIMEOUT cycles, err sticks until next accept.
        run_burst(32'h0000_3000, 3, 100000, 32'h0, 1'b0, 100, 1'b0);
        check_model(32'h0000_3000, 3, 100000, 32'h0);
        check("timeout_done_latency", 32'(done_cyc - acc_cyc), 32'(TIMEOUT + 2));
        repeat (5) step();
        check("err_held_in_idle", 32'(err), 32'd1);
        check("idle_after_timeout", 32'(busy), 32'd0);
        run_burst(32'h0000_0500, 1, 1, 32'h1234_5678, 1'b0, 100, 1'b0);
        check_model(32'h0000_0500, 1, 1, 32'h1234_5678);

        // Reset while word 3 of an 8-word burst is on the bus.
        configure(1, 32'h0, 1'b0, 100, 1'b0);
        clear_obs();
        issue_cmd(32'h0000_1000, 8);
        n = 0;
        while (!(bus_addr_q.size() == 3 && mem_valid) && n < 200) begin
            step();
            n++;
        end
        check("reached_word3", 32'(bus_addr_q.size()), 32'd3);
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        check("no_done_after_rst", 32'(done_cnt), 32'(d0));
        run_burst(32'h0000_0040, 2, 1, 32'hCAFE_0000, 1'b0, 100, 1'b0);
        check_model(32'h0000_0040, 2, 1, 32'hCAFE_0000);

        for (int r = 0; r < 25; r++) begin
            addr = $urandom;
            if ($urandom_range(4) == 0) addr = 32'hFFFF_FFE0 | 32'($urandom_range(31));
            len = $urandom_range(0, 12);
            lat = ($urandom_range(7) == 0) ? $urandom_range(60, 66) : $urandom_range(0, 3);
            run_burst(addr, len, lat, $urandom, 1'b0, $urandom_range(30, 100), 1'($urandom_range(1)));
            check_model(addr, len, lat, resp_key);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
